reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised reset controller: asserts reset asynchronously and releases it synchronously through a configurable synchroniser depth.
- Holds reset for a programmable stretch period, then releases NUM_CH reset domains one at a time in index order, with a programmable stagger between releases.
- Accepts a synchronous software reset request that re-runs the stretch-and-release sequence without the synchroniser.
- Sits at the top level between the board reset pin and the UART TX/RX, baud generator and FIFO domains.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on the deassert path; minimum 2.
- STRETCH, 16, clock edges reset stays asserted after the synchroniser releases; minimum 1.
- STAGGER, 8, clock edges between successive channel releases; minimum 1.
- NUM_CH, 4, number of reset output channels; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- sw_rst_req  input  1  software reset request; synchronous to clk, active-high.
- rst_out  output  NUM_CH  per-domain reset, active-high; bit 0 released first.
- busy  output  1  high while any rst_out bit is high.
- all_released  output  1  high once every channel is released; registered.

Behaviour:
- Async assert: rst=0 immediately, with no clock required, drives:
  - rst_out all ones, busy=1, all_released=0;
  - synchroniser chain, counter and channel index cleared;
  - FSM forced to WAIT_SYNC.
- Sync release: rst=1 shifts 1s into the chain. The internal released flag rises after the SYNC_STAGES-th rising edge following deassert.
- FSM states:
  - WAIT_SYNC: to STRETCH when the released flag is sampled 1.
  - STRETCH: counts edges; at count STRETCH, clears rst_out[0], index=1, goes to STAGGER. If NUM_CH=1, goes to DONE.
  - STAGGER: counts edges; at count STAGGER, clears rst_out[index] and increments the index. When the last channel is cleared, goes to DONE.
  - DONE: rst_out all zero, all_released=1.
- Counted edges are edges where the released flag is 1 and sw_rst_req=0. The counter resets to 0 on each state entry.
- Required timing after rst deasserts between edges 0 and 1:
  - rst_out[k] falls at edge SYNC_STAGES+STRETCH+k*STAGGER.
  - all_released rises at the same edge as rst_out[NUM_CH-1] falls.
  - With defaults: channels fall at edges 18, 26, 34, 42.
- Software reset: sw_rst_req=1 sampled at edge R, in any state after WAIT_SYNC:
  - At edge R: rst_out all ones, all_released=0, counter=0, index=0, FSM to STRETCH.
  - While the request stays high, outputs stay asserted and the counter holds at 0.
  - After the request drops, rst_out[0] falls at edge R'+STRETCH, where R' is the last edge sampling the request high. Later channels follow the stagger rule.
- sw_rst_req during WAIT_SYNC is ignored.
- Simultaneous events:
  - sw_rst_req=1 on the same edge a channel would release: the request wins and nothing releases.
  - rst asserting at any time: overrides everything asynchronously.
- rst glitching low mid-sequence (including in DONE): full async reassert, then the whole sequence restarts from WAIT_SYNC.
- Counter width: clog2(max(STRETCH,STAGGER)+1). Channel index width: clog2(NUM_CH+1).
- busy = OR of rst_out, driven from the registers (no combinational path from inputs).
- rst_out bits are registered. They are never released out of order and never re-released without a new sequence.

Test Plan:
1. Defaults, rst low for 5 clocks, then high; sw_rst_req=0 -> rst_out=1111 until edge 18, then 1110@18, 1100@26, 1000@34, 0000@42. all_released rises @42, busy falls @42.
2. rst pulsed low for 3ns between clock edges while in DONE -> rst_out=1111 and all_released=0 immediately without a clock edge. Release timing then repeats exactly as in scenario 1.
3. In DONE, sw_rst_req high for 1 edge at edge R -> rst_out=1111 at R; 1110 at R+16, 0000 at R+40. No synchroniser delay is added.
4. sw_rst_req high for 10 edges starting at edge 30 (mid-stagger, rst_out=1100) -> rst_out=1111 from edge 30. Counting starts after the request drops: first release at edge 39+16=55.
5. sw_rst_req asserted on the exact edge rst_out[2] would release (edge 34) -> rst_out=1111 at edge 34, with no partial release.
6. SYNC_STAGES=3, STRETCH=1, STAGGER=1, NUM_CH=1 -> rst_out[0] falls at edge 4, all_released=1 at edge 4.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board reset controller: asynchronous assert, synchronised release, then a stretch period
// followed by staggered in-order release of NUM_CH reset domains.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRETCH     = 16,
    parameter int unsigned STAGGER     = 8,
    parameter int unsigned NUM_CH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              busy,
    output logic              all_released
);

    localparam int unsigned CntMax = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        StWaitSync,
        StStretch,
        StStagger,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0] rst_out_q, rst_out_d;
    logic              all_rel_q, all_rel_d;
    logic              released, counted, stretch_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign released = sync_q[SYNC_STAGES-1];
    assign counted  = released && !sw_rst_req;
    // The edge that leaves WAIT_SYNC is already the first counted stretch edge.
    assign stretch_tick = (state_q == StWaitSync && released) ||
                          (state_q == StStretch && counted);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        all_rel_d = all_rel_q;
        if (state_q != StWaitSync && sw_rst_req) begin
            state_d   = StStretch;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            all_rel_d = 1'b0;
        end else if (stretch_tick) begin
            if (32'(cnt_q) + 32'd1 >= STRETCH) begin
                rst_out_d[0] = 1'b0;
                cnt_d        = '0;
                idx_d        = IdxW'(1);
                state_d      = (NUM_CH == 1) ? StDone : StStagger;
                all_rel_d    = (NUM_CH == 1);
            end else begin
                cnt_d   = cnt_q + CntW'(1);
                state_d = StStretch;
            end
        end else if (state_q == StStagger && counted) begin
            if (32'(cnt_q) + 32'd1 >= STAGGER) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (32'(idx_q) == i) rst_out_d[i] = 1'b0;
                end
                cnt_d = '0;
                idx_d = idx_q + IdxW'(1);
                if (32'(idx_q) == NUM_CH - 1) begin
                    state_d   = StDone;
                    all_rel_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StWaitSync;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            all_rel_q <= all_rel_d;
        end
    end

    assign rst_out      = rst_out_q;
    assign busy         = |rst_out_q;
    assign all_released = all_rel_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a minimal single-channel instance, both
// checked every edge against a release-time model.
module tb_reset_sequencer;

    localparam int S0 = 2, T0 = 16, G0 = 8, N0 = 4;
    localparam int S1 = 3, T1 = 1, G1 = 1, N1 = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic [N0-1:0] rst_out0;
    logic [N1-1:0] rst_out1;
    logic          busy0, busy1, all_rel0, all_rel1;

    int checks = 0;
    int errors = 0;
    int e      = 0;   // edges since rst deasserted
    int b0     = S0;  // sequence base edge: channel k falls at b + STRETCH + k*STAGGER
    int b1     = S1;

    always #5 clk = ~clk;

    reset_sequencer #(.SYNC_STAGES(S0), .STRETCH(T0), .STAGGER(G0), .NUM_CH(N0)) dut0 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .rst_out(rst_out0), .busy(busy0), .all_released(all_rel0)
    );

    reset_sequencer #(.SYNC_STAGES(S1), .STRETCH(T1), .STAGGER(G1), .NUM_CH(N1)) dut1 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .rst_out(rst_out1), .busy(busy1), .all_released(all_rel1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_out(int edge_n, int b, int st, int sg, int n);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v[k] = (edge_n < b + st + k * sg);
        return v;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] x0, x1;
        if (!rst) begin
            x0 = 32'hF;
            x1 = 32'h1;
            check({tag, "_all0"}, 32'(all_rel0), 32'd0);
            check({tag, "_all1"}, 32'(all_rel1), 32'd0);
        end else begin
            x0 = exp_out(e, b0, T0, G0, N0);
            x1 = exp_out(e, b1, T1, G1, N1);
            check({tag, "_all0"}, 32'(all_rel0), 32'(e >= b0 + T0 + (N0 - 1) * G0));
            check({tag, "_all1"}, 32'(all_rel1), 32'(e >= b1 + T1 + (N1 - 1) * G1));
        end
        check({tag, "_out0"}, 32'(rst_out0), x0);
        check({tag, "_out1"}, 32'(rst_out1), x1);
        check({tag, "_busy0"}, 32'(busy0), 32'(x0 != 0));
        check({tag, "_busy1"}, 32'(busy1), 32'(x1 != 0));
    endtask

    // Called at posedge+1; drives sw for the next edge, then checks after it.
    task automatic tick(input logic sw_v);
        sw_rst_req = sw_v;
        @(posedge clk);
        e++;
        // A request is ignored while the FSM still sits in WAIT_SYNC (up to edge S+1).
        if (sw_v && e >= S0 + 2) b0 = e;
        if (sw_v && e >= S1 + 2) b1 = e;
        #1;
        check_all("edge");
    endtask

    task automatic do_reset(input int hold);
        #2;
        rst = 1'b0;
        #1;
        check_all("async");
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
                check_all("held");
            end
        end
        #2;
        rst = 1'b1;
        e  = 0;
        b0 = S0;
        b1 = S1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_all("por");
        do_reset(5);
        // Defaults: releases at 18, 26, 34, 42.
        repeat (50) tick(1'b0);
        check("s1_done", 32'(rst_out0), 32'h0);

        // Short glitch in DONE, then the full sequence again.
        do_reset(0);
        repeat (45) tick(1'b0);

        // Single-edge request in DONE.
        tick(1'b1);
        repeat (45) tick(1'b0);

        // Ten-edge request starting at edge 30 of a fresh sequence.
        do_reset(2);
        repeat (29) tick(1'b0);
        repeat (10) tick(1'b1);
        repeat (45) tick(1'b0);

        // Request on the exact edge channel 2 would release.
        do_reset(1);
        repeat (33) tick(1'b0);
        tick(1'b1);
        check("s5_edge34", 32'(rst_out0), 32'hF);
        repeat (45) tick(1'b0);

        // Randomised requests and occasional reset glitches.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(0, 3)));
            tick(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
